// File: rtl/regs_mp_pkg.sv
// rtl/regs_mp_pkg.sv - shared state type, byte width and strobe merge helper for regs_mp
package regs_mp_pkg;

    localparam int BYTE_W     = 8;
    // Widest bus the merge helper handles; callers cast to and from their own width.
    localparam int MAX_BUS_W  = 1024;
    localparam int MAX_STRB_W = MAX_BUS_W / BYTE_W;

    typedef enum logic {
        CLEAR,
        RUN
    } regs_mp_state_t;

    function automatic logic [MAX_BUS_W-1:0] strb_merge(
        input logic [MAX_BUS_W-1:0]  old_w,
        input logic [MAX_BUS_W-1:0]  new_w,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_BUS_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            if (strb[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regs_mp_rdport.sv
// rtl/regs_mp_rdport.sv - one registered read port: range check, write bypass, output register
// Optional feature: REGS_MP_ZERO_REG_EN forces reads of address 0 to zero.
module regs_mp_rdport
    import regs_mp_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int REGS_NUM   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = BUS_WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BUS_WIDTH-1:0]  rd_word,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    output logic [BUS_WIDTH-1:0]  rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(REGS_NUM);

    logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_ok;
    logic [BUS_WIDTH-1:0] word;

    always_comb begin
        rd_ok = (rd_addr < ADDR_LIMIT);
`ifdef REGS_MP_ZERO_REG_EN
        rd_ok = rd_ok && (rd_addr != '0);
`endif
        word = rd_word;
        // Write-first: a same-cycle write to this address is merged into the returned word.
        if (wr_en && (wr_addr == rd_addr)) begin
            word = BUS_WIDTH'(strb_merge(MAX_BUS_W'(rd_word), MAX_BUS_W'(wr_data),
                                         MAX_STRB_W'(wr_strb)));
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_ok ? word : '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/regs_mp.sv
// rtl/regs_mp.sv - multi-port register file with sequenced clear and write-to-read bypass
// Optional feature: REGS_MP_ZERO_REG_EN hardwires register 0 to zero.
module regs_mp
    import regs_mp_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int REGS_NUM   = 16,
    parameter int ADDR_WIDTH = 32,
    localparam int STRB_WIDTH = BUS_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [BUS_WIDTH-1:0]  rd_data_a,
    output logic [BUS_WIDTH-1:0]  rd_data_b,
    output logic                  rd_valid_a,
    output logic                  rd_valid_b,
    output logic                  ready
);

    localparam int                    IDX_W      = $clog2(REGS_NUM);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(REGS_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(REGS_NUM);

    regs_mp_state_t   state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // No reset on the array: the clear engine zeroes it instead.
    logic [BUS_WIDTH-1:0] regs_mem [REGS_NUM];

    logic                 accept;
    logic                 wr_ok;
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_idx;
    logic [BUS_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = ptr_q;
        mem_wdata = '0;
        wr_ok     = wr_en && (wr_addr < ADDR_LIMIT) && (|wr_strb);
`ifdef REGS_MP_ZERO_REG_EN
        wr_ok     = wr_ok && (wr_addr != '0);
`endif
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else begin
                    accept = 1'b1;
                    if (wr_ok) begin
                        mem_we    = 1'b1;
                        mem_idx   = wr_addr[IDX_W-1:0];
                        mem_wdata = BUS_WIDTH'(strb_merge(MAX_BUS_W'(regs_mem[wr_addr[IDX_W-1:0]]),
                                                          MAX_BUS_W'(wr_data),
                                                          MAX_STRB_W'(wr_strb)));
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_mem[mem_idx] <= mem_wdata;
        end
    end

    assign ready = (state_q == RUN);

    regs_mp_rdport #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGS_NUM  (REGS_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_rdport_a (
        .clk     (clk),
        .nreset  (nreset),
        .rd_en   (accept && rd_en_a),
        .rd_addr (rd_addr_a),
        .rd_word (regs_mem[rd_addr_a[IDX_W-1:0]]),
        .wr_en   (accept && wr_en),
        .wr_addr (wr_addr),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .rd_data (rd_data_a),
        .rd_valid(rd_valid_a)
    );

    regs_mp_rdport #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGS_NUM  (REGS_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_rdport_b (
        .clk     (clk),
        .nreset  (nreset),
        .rd_en   (accept && rd_en_b),
        .rd_addr (rd_addr_b),
        .rd_word (regs_mem[rd_addr_b[IDX_W-1:0]]),
        .wr_en   (accept && wr_en),
        .wr_addr (wr_addr),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .rd_data (rd_data_b),
        .rd_valid(rd_valid_b)
    );

endmodule

// File: tb/tb_regs_mp.sv
// tb/tb_regs_mp.sv - scoreboard testbench for regs_mp (honours REGS_MP_ZERO_REG_EN)
module tb_regs_mp;

    logic        clk = 1'b0;
    logic        nreset;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        rd_en_a, rd_en_b;
    logic [31:0] rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    always #5 clk = ~clk;

    regs_mp dut (
        .clk       (clk),
        .nreset    (nreset),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_strb   (wr_strb),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid_a(rd_valid_a),
        .rd_valid_b(rd_valid_b),
        .ready     (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (exp_a.size() == 0) check("rd_a_unexpected_valid", 32'd1, 32'd0);
            else check("rd_data_a", rd_data_a, exp_a.pop_front());
        end
        if (rd_valid_b) begin
            if (exp_b.size() == 0) check("rd_b_unexpected_valid", 32'd1, 32'd0);
            else check("rd_data_b", rd_data_b, exp_b.pop_front());
        end
    end

    task automatic idle();
        clear = 0; wr_en = 0; wr_addr = 0; wr_strb = 0; wr_data = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
    endtask

    // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
    task automatic op(input logic we, input logic [31:0] wa, input logic [3:0] ws,
                      input logic [31:0] wd,
                      input logic rea, input logic [31:0] ra, input logic [31:0] ea,
                      input logic reb, input logic [31:0] rb, input logic [31:0] eb);
        wr_en = we; wr_addr = wa; wr_strb = ws; wr_data = wd;
        rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;
        if (rea) exp_a.push_back(ea);
        if (reb) exp_b.push_back(eb);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        op(1, a, s, d, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] zero_exp;
    int          wait_cnt;

    initial begin
`ifdef REGS_MP_ZERO_REG_EN
        zero_exp = 32'h0000_0000;
`else
        zero_exp = 32'hFFFF_FFFF;
`endif
        idle();
        nreset = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 0);
        check("reset_valid_a", {31'd0, rd_valid_a}, 0);
        check("reset_valid_b", {31'd0, rd_valid_b}, 0);
        check("reset_data_a", rd_data_a, 0);
        check("reset_data_b", rd_data_b, 0);

        // Release reset with traffic present: CLEAR must ignore it.
        nreset = 1;
        wr_en = 1; wr_addr = 1; wr_strb = 4'hF; wr_data = 32'h55;
        rd_en_a = 1; rd_en_b = 1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            check($sformatf("init_ready_edge%0d", i), {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        idle();

        for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, i, 0, 1, 15 - i, 0);

        wr(5, 4'b1111, 32'hDEADBEEF);
        wr(5, 4'b0101, 32'h11223344);
        op(0, 0, 0, 0, 1, 5, 32'hDE22BE44, 0, 0, 0);

        op(1, 3, 4'hF, 32'hCAFEF00D, 1, 3, 32'hCAFEF00D, 1, 3, 32'hCAFEF00D);
        op(1, 5, 4'b1000, 32'hAABBCCDD, 1, 5, 32'hAA22BE44, 1, 3, 32'hCAFEF00D);
        op(0, 0, 0, 0, 1, 5, 32'hAA22BE44, 0, 0, 0);

        op(1, 16, 4'hF, 32'h12345678, 1, 40, 32'h0, 1, 0, 32'h0);
        op(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h1000_0005, 32'h0);
        wr(6, 4'b0000, 32'hFFFF_FFFF);
        op(0, 0, 0, 0, 1, 6, 32'h0, 0, 0, 0);

        for (int i = 1; i < 16; i++) wr(i, 4'hF, 32'h0101_0101 * i + 32'h10);
        wr(0, 4'hF, 32'h0000_0077);
        op(0, 0, 0, 0, 1, 9, 32'h0909_0919, 1, 15, 32'h0F0F_0F1F);

        // Clear request with a concurrent read and write that must both be dropped.
        clear = 1; wr_en = 1; wr_addr = 2; wr_strb = 4'hF; wr_data = 32'hFF;
        rd_en_a = 1; rd_addr_a = 2;
        @(posedge clk); #1;
        check("clear_ready_edge0", {31'd0, ready}, 0);
        clear = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            check($sformatf("clear_ready_edge%0d", i), {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, i, 0, 1, i, 0);

        op(1, 0, 4'hF, 32'hFFFF_FFFF, 1, 0, zero_exp, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, zero_exp, 1, 0, zero_exp);

        // Asynchronous reset mid-RUN drops an in-flight valid immediately.
        rd_en_a = 1; rd_addr_a = 4;
        @(posedge clk); #1;
        rd_en_a = 0;
        nreset = 0;
        #1;
        check("async_rst_valid_a", {31'd0, rd_valid_a}, 0);
        check("async_rst_ready", {31'd0, ready}, 0);
        @(negedge clk);
        nreset = 1;
        wait_cnt = 0;
        while (!ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("rst_recover_ready", {31'd0, ready}, 1);
        check("rst_recover_cycles", wait_cnt, 16);

        @(negedge clk);
        @(negedge clk);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
